// File: rtl/core_ex_lsu_ctrl.sv
// EX-stage load/store controller: one outstanding memory request with
// lane alignment, load extension, exceptions, timeout and flush handling.
module core_ex_lsu_ctrl #(
    parameter int XLEN    = 64,
    parameter int ADDR_W  = 64,
    parameter int RFIDX_W = 5,
    parameter int TIMEOUT = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               valid_in,
    output logic               ready_in,
    input  logic               i_load,
    input  logic               i_store,
    input  logic [1:0]         i_size,
    input  logic               i_unsigned,
    input  logic [ADDR_W-1:0]  i_addr,
    input  logic [XLEN-1:0]    i_wdata,
    input  logic [RFIDX_W-1:0] i_rd_idx,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [ADDR_W-1:0]  mem_req_addr,
    output logic               mem_req_wen,
    output logic [XLEN-1:0]    mem_req_wdata,
    output logic [XLEN/8-1:0]  mem_req_wmask,
    input  logic               mem_rsp_valid,
    output logic               mem_rsp_ready,
    input  logic [XLEN-1:0]    mem_rsp_rdata,
    input  logic               mem_rsp_err,
    output logic               valid_out,
    input  logic               ready_out,
    output logic [RFIDX_W-1:0] o_rd_idx,
    output logic               o_rd_wen,
    output logic [XLEN-1:0]    o_rdata,
    output logic               o_exc_misalign,
    output logic               o_exc_bus
);

    localparam int BYTES = XLEN / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TLIM  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TMAX = CNT_W'(TLIM);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_d;

    logic               load_q, store_q, uns_q;
    logic [1:0]         size_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [XLEN-1:0]    wdata_q;
    logic [RFIDX_W-1:0] rd_q;
    logic               flushed_q, flushed_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    res_rdata_q, res_rdata_d;
    logic               res_wen_q, res_wen_d;
    logic               res_mis_q, res_mis_d;
    logic               res_bus_q, res_bus_d;

    logic               accept;
    logic               mis_in;
    logic               bad_size;
    logic               tmo;
    logic [OFF_W-1:0]   off;
    logic [BYTES-1:0]   base_mask;

    function automatic logic [XLEN-1:0] ext_load(
        input logic [XLEN-1:0]  raw,
        input logic [OFF_W-1:0] o,
        input logic [1:0]       sz,
        input logic             uns
    );
        logic [XLEN-1:0] s;
        s = raw >> {o, 3'b000};
        unique case (sz)
            2'd0: ext_load = uns ? XLEN'(s[7:0]) : XLEN'($signed(s[7:0]));
            2'd1: ext_load = uns ? XLEN'(s[15:0]) : XLEN'($signed(s[15:0]));
            2'd2: ext_load = uns ? XLEN'(s[31:0]) : XLEN'($signed(s[31:0]));
            default: ext_load = s;
        endcase
    endfunction

    always_comb begin
        unique case (i_size)
            2'd0: mis_in = 1'b0;
            2'd1: mis_in = i_addr[0];
            2'd2: mis_in = |i_addr[1:0];
            default: mis_in = |i_addr[2:0];
        endcase
    end

    assign bad_size = (XLEN == 32) && (i_size == 2'd3);
    assign tmo      = (TIMEOUT != 0) && (cnt_q == TMAX);
    assign off      = addr_q[OFF_W-1:0];

    always_comb begin
        base_mask = '0;
        for (int i = 0; i < BYTES; i++) begin
            base_mask[i] = (i < (1 << size_q));
        end
    end

    always_comb begin
        state_d     = state;
        accept      = 1'b0;
        flushed_d   = flushed_q;
        cnt_d       = cnt_q;
        res_rdata_d = res_rdata_q;
        res_wen_d   = res_wen_q;
        res_mis_d   = res_mis_q;
        res_bus_d   = res_bus_q;
        unique case (state)
            IDLE: begin
                if (valid_in && !flush) begin
                    accept    = 1'b1;
                    flushed_d = 1'b0;
                    if (mis_in || bad_size || !(i_load || i_store)) begin
                        // Resolved locally: no memory request is issued
                        state_d     = DONE;
                        res_rdata_d = '0;
                        res_wen_d   = 1'b0;
                        res_mis_d   = i_load || i_store;
                        res_bus_d   = 1'b0;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (flush) flushed_d = 1'b1;
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = (flushed_q || flush) ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_rsp_valid) begin
                    state_d     = flush ? IDLE : DONE;
                    res_bus_d   = mem_rsp_err;
                    res_mis_d   = 1'b0;
                    res_wen_d   = load_q && (rd_q != '0) && !mem_rsp_err;
                    res_rdata_d = (load_q && !mem_rsp_err)
                                ? ext_load(mem_rsp_rdata, off, size_q, uns_q)
                                : '0;
                end else if (tmo) begin
                    state_d     = flush ? IDLE : DONE;
                    res_bus_d   = 1'b1;
                    res_mis_d   = 1'b0;
                    res_wen_d   = 1'b0;
                    res_rdata_d = '0;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_rsp_valid || tmo) state_d = IDLE;
            end
            DONE: begin
                // Flush and ready_out both return to IDLE; flush just drops the result
                if (flush || ready_out) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            load_q      <= 1'b0;
            store_q     <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            flushed_q   <= 1'b0;
            cnt_q       <= '0;
            res_rdata_q <= '0;
            res_wen_q   <= 1'b0;
            res_mis_q   <= 1'b0;
            res_bus_q   <= 1'b0;
        end else begin
            state       <= state_d;
            flushed_q   <= flushed_d;
            cnt_q       <= cnt_d;
            res_rdata_q <= res_rdata_d;
            res_wen_q   <= res_wen_d;
            res_mis_q   <= res_mis_d;
            res_bus_q   <= res_bus_d;
            if (accept) begin
                load_q  <= i_load;
                store_q <= i_store;
                uns_q   <= i_unsigned;
                size_q  <= i_size;
                addr_q  <= i_addr;
                wdata_q <= i_wdata;
                rd_q    <= i_rd_idx;
            end
        end
    end

    assign ready_in       = (state == IDLE) && !flush;
    assign mem_req_valid  = (state == REQ);
    assign mem_req_addr   = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign mem_req_wen    = store_q;
    assign mem_req_wdata  = store_q ? (wdata_q << {off, 3'b000}) : '0;
    assign mem_req_wmask  = store_q ? (base_mask << off) : '0;
    assign mem_rsp_ready  = (state == IDLE) || (state == WAIT) || (state == DRAIN);
    assign valid_out      = (state == DONE);
    assign o_rd_idx       = rd_q;
    assign o_rd_wen       = res_wen_q;
    assign o_rdata        = res_rdata_q;
    assign o_exc_misalign = res_mis_q;
    assign o_exc_bus      = res_bus_q;

endmodule
